mem_responder: RTL and testbench



---
 rtl/mem_map_pkg.sv | 21 ++
 rtl/mem_array.sv | 27 ++
 rtl/mem_responder.sv | 148 ++++++++++++++
 tb/tb_mem_responder.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_map_pkg.sv
// Shared memory-map constants and FSM state encoding for the memory responder.
package mem_map_pkg;

  localparam logic [31:0] MMIO_BASE  = 32'h4000_0000;
  localparam logic [3:0]  LED_OFFSET = 4'h0;
  localparam logic [3:0]  CNT_OFFSET = 4'h4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SEL_RAM  = 2'd0,
    SEL_LED  = 2'd1,
    SEL_CNT  = 2'd2,
    SEL_NONE = 2'd3
  } sel_t;

endpackage

// File: rtl/mem_array.sv
// Word-wide RAM: combinational read of the addressed word, synchronous write, full clear on reset.
module mem_array #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: RAM plus LED/cycle-counter registers behind a four-phase
// request/ready handshake with a configurable number of wait states.
import mem_map_pkg::*;

module mem_responder #(
  parameter int          ADDR_WIDTH  = 8,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] MMIO_BASE   = mem_map_pkg::MMIO_BASE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] Write_data,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [31:0] Mem_data,
  output logic        Mem_ready,
  output logic [7:0]  led,
  output logic        addr_err
);

  localparam int          WCW      = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam int          WLOAD_I  = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
  localparam logic [WCW-1:0] WLOAD = WCW'(WLOAD_I);
  localparam logic [31:0] LED_ADDR = MMIO_BASE + {28'h0, LED_OFFSET};
  localparam logic [31:0] CNT_ADDR = MMIO_BASE + {28'h0, CNT_OFFSET};

  state_t           state, next_state;
  logic [WCW-1:0]   wcnt;
  logic [31:0]      addr_q, wdata_q;
  logic             wr_q;
  logic [31:0]      cnt;
  logic             req, accept, enter_done;
  logic [31:0]      acc_addr, acc_wdata;
  logic             acc_wr;
  sel_t             sel;
  logic             ram_we;
  logic [31:0]      ram_rdata, rd_val;

  assign req    = MemRead | MemWrite;
  assign accept = (state == IDLE) && req;

  // With zero wait states the access happens on the accept edge itself, so the
  // live request is used there; otherwise the copy latched at accept is used.
  assign acc_addr  = (state == IDLE) ? Address    : addr_q;
  assign acc_wdata = (state == IDLE) ? Write_data : wdata_q;
  assign acc_wr    = (state == IDLE) ? MemWrite   : wr_q;

  always_comb begin
    sel = SEL_NONE;
    if ((acc_addr >> (ADDR_WIDTH + 2)) == 32'd0)  sel = SEL_RAM;
    else if (acc_addr[31:2] == LED_ADDR[31:2])    sel = SEL_LED;
    else if (acc_addr[31:2] == CNT_ADDR[31:2])    sel = SEL_CNT;
  end

  always_comb begin
    next_state = state;
    enter_done = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) begin
          if (WAIT_CYCLES == 0) begin
            next_state = DONE;
            enter_done = 1'b1;
          end else begin
            next_state = BUSY;
          end
        end
      end
      BUSY: begin
        if (wcnt == '0) begin
          next_state = DONE;
          enter_done = 1'b1;
        end
      end
      DONE: begin
        if (!req) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  assign Mem_ready = (state == DONE);

  assign ram_we = enter_done && acc_wr && (sel == SEL_RAM);

  mem_array #(.ADDR_WIDTH(ADDR_WIDTH)) u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (ram_we),
    .addr  (acc_addr[ADDR_WIDTH+1:2]),
    .wdata (acc_wdata),
    .rdata (ram_rdata)
  );

  always_comb begin
    rd_val = '0;
    unique case (sel)
      SEL_RAM: rd_val = ram_rdata;
      SEL_LED: rd_val = {24'h0, led};
      SEL_CNT: rd_val = cnt;
      default: rd_val = '0;
    endcase
  end

  // Request latch, wait counter, registers and the response word.
  always_ff @(posedge clk) begin
    if (reset) begin
      wcnt     <= '0;
      wr_q     <= 1'b0;
      cnt      <= '0;
      led      <= '0;
      addr_err <= 1'b0;
      Mem_data <= '0;
    end else begin
      cnt <= cnt + 32'd1;
      if (accept) begin
        wr_q <= MemWrite;
        wcnt <= WLOAD;
        if (MemRead && MemWrite) addr_err <= 1'b1;
      end else if ((state == BUSY) && (wcnt != '0)) begin
        wcnt <= wcnt - 1'b1;
      end
      if (enter_done) begin
        if (sel == SEL_NONE) addr_err <= 1'b1;
        if (acc_wr) begin
          Mem_data <= '0;
          if (sel == SEL_LED) led <= acc_wdata[7:0];
        end else begin
          Mem_data <= rd_val;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= Address;
      wdata_q <= Write_data;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: a two-wait-state instance and a zero-wait instance share the request bus.
import mem_map_pkg::*;

module tb_mem_responder;

  localparam int WAIT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Address, Write_data;
  logic        MemRead, MemWrite;
  logic [31:0] Mem_data, Mem_data0;
  logic        Mem_ready, Mem_ready0;
  logic [7:0]  led, led0;
  logic        addr_err, addr_err0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(WAIT)) dut (
    .clk(clk), .reset(reset), .Address(Address), .Write_data(Write_data),
    .MemRead(MemRead), .MemWrite(MemWrite), .Mem_data(Mem_data),
    .Mem_ready(Mem_ready), .led(led), .addr_err(addr_err)
  );

  mem_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .Address(Address), .Write_data(Write_data),
    .MemRead(MemRead), .MemWrite(MemWrite), .Mem_data(Mem_data0),
    .Mem_ready(Mem_ready0), .led(led0), .addr_err(addr_err0)
  );

  // One full four-phase transaction; optional expected read data goes through the scoreboard.
  task automatic xact(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                      input bit chk, input logic [31:0] exp,
                      output logic [31:0] q, output logic [31:0] q0, output int t);
    int lat, lat0;
    logic [31:0] e;
    q0 = 'x;
    @(negedge clk);
    Address = a; Write_data = d; MemRead = rd; MemWrite = wr;
    if (chk) exp_q.push_back(exp);
    lat = 0; lat0 = 0;
    do begin
      @(posedge clk); #1; lat++;
      if (lat0 == 0 && Mem_ready0 === 1'b1) begin lat0 = lat; q0 = Mem_data0; end
    end while (Mem_ready !== 1'b1 && lat < 20);
    t = cyc;
    q = Mem_data;
    checks++;
    if (lat !== WAIT + 1) begin errors++; $display("FAIL latency addr=%h got %0d want %0d", a, lat, WAIT + 1); end
    checks++;
    if (lat0 !== 1) begin errors++; $display("FAIL latency_w0 addr=%h got %0d want 1", a, lat0); end
    if (chk) begin
      e = exp_q.pop_front();
      checks++;
      if (q !== e) begin errors++; $display("FAIL data addr=%h got %h want %h", a, q, e); end
    end
    @(negedge clk);
    MemRead = 1'b0; MemWrite = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (Mem_ready !== 1'b0) begin errors++; $display("FAIL ready_drop got %b want 0", Mem_ready); end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (Mem_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b want 0", Mem_ready); end
    checks++;
    if (Mem_data !== 32'h0) begin errors++; $display("FAIL rst_data got %h want 0", Mem_data); end
    checks++;
    if (led !== 8'h0) begin errors++; $display("FAIL rst_led got %h want 0", led); end
    checks++;
    if (addr_err !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", addr_err); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_ram();
    logic [31:0] q, q0; int t;
    xact(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 32'h0, q, q0, t);
    xact(1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b1, 32'hDEAD_BEEF, q, q0, t);
    xact(1'b0, 1'b1, 32'h0000_03FC, 32'h1234_5678, 1'b1, 32'h0, q, q0, t);
    xact(1'b1, 1'b0, 32'h0000_03FC, 32'h0, 1'b1, 32'h1234_5678, q, q0, t);
    xact(1'b1, 1'b0, 32'h0000_0013, 32'h0, 1'b1, 32'hDEAD_BEEF, q, q0, t);
    checks++;
    if (addr_err !== 1'b0) begin errors++; $display("FAIL ram_err got %b want 0", addr_err); end
  endtask

  task automatic test_handshake();
    logic [31:0] v;
    int n;
    @(negedge clk);
    Address = 32'h4000_0004; MemRead = 1'b1; MemWrite = 1'b0;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (Mem_ready !== 1'b1 && n < 20);
    checks++;
    if (Mem_ready !== 1'b1) begin errors++; $display("FAIL hs_ready timeout got %b want 1", Mem_ready); end
    v = Mem_data;
    Address = 32'h0000_0010;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (Mem_ready !== 1'b1 || Mem_data !== v) begin
        errors++;
        $display("FAIL hs_hold cycle %0d ready=%b data=%h want ready=1 data=%h", i, Mem_ready, Mem_data, v);
      end
    end
    @(negedge clk);
    MemRead = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (Mem_ready !== 1'b0) begin errors++; $display("FAIL hs_drop got %b want 0", Mem_ready); end
    checks++;
    if (dut.state !== IDLE) begin errors++; $display("FAIL hs_state got %0d want %0d", dut.state, IDLE); end
    checks++;
    if (Mem_data !== v) begin errors++; $display("FAIL hs_data_hold got %h want %h", Mem_data, v); end
  endtask

  task automatic test_mmio();
    logic [31:0] q, q0, c1, c2, c3; int t1, t2, t3;
    xact(1'b0, 1'b1, 32'h4000_0000, 32'h0000_01A5, 1'b1, 32'h0, q, q0, t1);
    checks++;
    if (led !== 8'hA5) begin errors++; $display("FAIL led got %h want a5", led); end
    xact(1'b1, 1'b0, 32'h4000_0000, 32'h0, 1'b1, 32'h0000_00A5, q, q0, t1);
    xact(1'b1, 1'b0, 32'h4000_0004, 32'h0, 1'b0, 32'h0, c1, q0, t1);
    repeat (7) @(posedge clk);
    xact(1'b1, 1'b0, 32'h4000_0004, 32'h0, 1'b0, 32'h0, c2, q0, t2);
    checks++;
    if (c2 - c1 !== 32'(t2 - t1)) begin errors++; $display("FAIL cnt_delta got %0d want %0d", c2 - c1, t2 - t1); end
    xact(1'b0, 1'b1, 32'h4000_0004, 32'h0, 1'b1, 32'h0, q, q0, t3);
    xact(1'b1, 1'b0, 32'h4000_0004, 32'h0, 1'b0, 32'h0, c3, q0, t3);
    checks++;
    if (c3 - c2 !== 32'(t3 - t2)) begin errors++; $display("FAIL cnt_after_write got %0d want %0d", c3 - c2, t3 - t2); end
    checks++;
    if (addr_err !== 1'b0) begin errors++; $display("FAIL mmio_err got %b want 0", addr_err); end
  endtask

  task automatic test_both();
    logic [31:0] q, q0; int t;
    xact(1'b1, 1'b1, 32'h0000_0000, 32'h5, 1'b1, 32'h0, q, q0, t);
    checks++;
    if (addr_err !== 1'b1) begin errors++; $display("FAIL both_err got %b want 1", addr_err); end
    xact(1'b1, 1'b0, 32'h0000_0000, 32'h0, 1'b1, 32'h5, q, q0, t);
  endtask

  task automatic test_unmapped();
    logic [31:0] q, q0; int t;
    checks++;
    if (addr_err !== 1'b0) begin errors++; $display("FAIL unm_pre_err got %b want 0", addr_err); end
    xact(1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b1, 32'h0, q, q0, t);
    xact(1'b1, 1'b0, 32'h0000_1000, 32'h0, 1'b1, 32'h0, q, q0, t);
    checks++;
    if (addr_err !== 1'b1) begin errors++; $display("FAIL unm_err got %b want 1", addr_err); end
    xact(1'b0, 1'b1, 32'h0000_1000, 32'hFFFF_FFFF, 1'b1, 32'h0, q, q0, t);
    xact(1'b1, 1'b0, 32'h0000_0000, 32'h0, 1'b1, 32'h0, q, q0, t);
    xact(1'b1, 1'b0, 32'h4000_0008, 32'h0, 1'b1, 32'h0, q, q0, t);
    checks++;
    if (addr_err !== 1'b1) begin errors++; $display("FAIL unm_sticky got %b want 1", addr_err); end
  endtask

  task automatic test_reset_mid_busy();
    logic [31:0] q, q0; int t;
    xact(1'b0, 1'b1, 32'h4000_0000, 32'h0000_005A, 1'b1, 32'h0, q, q0, t);
    @(negedge clk);
    Address = 32'h0000_0008; Write_data = 32'h0000_1234; MemWrite = 1'b1; MemRead = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1; MemWrite = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (Mem_ready !== 1'b0) begin errors++; $display("FAIL mid_ready got %b want 0", Mem_ready); end
    checks++;
    if (dut.state !== IDLE) begin errors++; $display("FAIL mid_state got %0d want %0d", dut.state, IDLE); end
    checks++;
    if (led !== 8'h0) begin errors++; $display("FAIL mid_led got %h want 0", led); end
    checks++;
    if (addr_err !== 1'b0) begin errors++; $display("FAIL mid_err got %b want 0", addr_err); end
    @(negedge clk);
    reset = 1'b0;
    xact(1'b1, 1'b0, 32'h0000_0008, 32'h0, 1'b1, 32'h0, q, q0, t);
  endtask

  task automatic test_wait0();
    logic [31:0] q, q0; int t;
    xact(1'b0, 1'b1, 32'h0000_0020, 32'hA5A5_0001, 1'b1, 32'h0, q, q0, t);
    xact(1'b1, 1'b0, 32'h0000_0020, 32'h0, 1'b1, 32'hA5A5_0001, q, q0, t);
    checks++;
    if (q0 !== 32'hA5A5_0001) begin errors++; $display("FAIL w0_data got %h want a5a50001", q0); end
  endtask

  initial begin
    reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0;
    Address = '0; Write_data = '0;
    test_reset();
    test_ram();
    test_handshake();
    test_mmio();
    do_reset();
    test_both();
    do_reset();
    test_unmapped();
    test_reset_mid_busy();
    test_wait0();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
